// File: rtl/cronometro_pkg.sv
// Shared definitions for the stopwatch run-control block.
//   crono_state_t  : run FSM state, encoding visible on the STATE output
//   DEF_TICK_DIV   : default clock cycles per count tick (1 Hz at 50 MHz)
//   DEF_DEB_CYCLES : default debounce length in clock cycles
package cronometro_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LAP   = 2'b11
  } crono_state_t;

  localparam int unsigned DEF_TICK_DIV   = 50_000_000;
  localparam int unsigned DEF_DEB_CYCLES = 1_000_000;

endpackage

// File: rtl/cronometro_btn_cond.sv
// btn_cond: conditions one asynchronous push-button.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn        : raw button level (asynchronous, active-high)
//   press      : registered one-cycle pulse on each debounced press
// Path: 2-flop synchronizer -> debounce counter -> rising-edge pulse.
// Release edges produce no pulse.
module btn_cond
  import cronometro_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  // +1 keeps the counter at least one bit wide when DEB_CYCLES is 1.
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_q;
  logic [CW-1:0] deb_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      deb_cnt <= '0;
      press   <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      // Count consecutive cycles where the synchronized input disagrees with
      // the debounced level; any agreeing cycle restarts the count.
      if (sync2 != level) begin
        if (deb_cnt == CW'(DEB_CYCLES - 1)) begin
          level   <= sync2;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + CW'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
      level_q <= level;
      press   <= level & ~level_q;
    end
  end

endmodule

// File: rtl/cronometro_ctrl.sv
// cronometro_ctrl: run-control sequencer for the stopwatch digit counters.
//   CLK, RST_N          : clock, asynchronous active-low reset
//   BTN_START/CLR/LAP   : raw push-buttons (asynchronous, active-high)
//   MAX_REACHED         : counter chain at 59:59 (only with CRONO_AUTOSTOP_EN)
//   CNT_EN              : one-cycle count tick to the least-significant digit
//   CNT_CLR             : one-cycle synchronous clear to all digits
//   DISP_HOLD           : display latch freeze, high only in LAP
//   RUNNING             : high in RUN or LAP
//   STATE               : FSM state (IDLE=00 RUN=01 PAUSE=10 LAP=11)
// Optional feature macro: CRONO_AUTOSTOP_EN (stop at 59:59 instead of wrap).
// All outputs are registered; RUNNING/DISP_HOLD are decoded from the next
// state so they change in the same cycle as STATE.
module cronometro_ctrl
  import cronometro_pkg::*;
#(
  parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       BTN_START,
  input  logic       BTN_CLR,
  input  logic       BTN_LAP,
`ifdef CRONO_AUTOSTOP_EN
  input  logic       MAX_REACHED,
`endif
  output logic       CNT_EN,
  output logic       CNT_CLR,
  output logic       DISP_HOLD,
  output logic       RUNNING,
  output logic [1:0] STATE
);

  localparam int PW = $clog2(TICK_DIV);

  logic          ev_start;
  logic          ev_clr;
  logic          ev_lap;
  logic          at_max;
  logic          wrap;
  logic          en_n;
  logic          clr_n;
  crono_state_t  st;
  crono_state_t  st_n;
  logic [PW-1:0] pre;
  logic [PW-1:0] pre_n;

  btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_btn_start (
    .clk(CLK), .rst_n(RST_N), .btn(BTN_START), .press(ev_start)
  );
  btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_btn_clr (
    .clk(CLK), .rst_n(RST_N), .btn(BTN_CLR), .press(ev_clr)
  );
  btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_btn_lap (
    .clk(CLK), .rst_n(RST_N), .btn(BTN_LAP), .press(ev_lap)
  );

`ifdef CRONO_AUTOSTOP_EN
  assign at_max = MAX_REACHED;
`else
  assign at_max = 1'b0;
`endif

  assign wrap = (pre == PW'(TICK_DIV - 1));

  // Events are tested in priority order clr > start > lap; an event that is
  // meaningless in the current state falls through to the next one.
  always_comb begin
    st_n  = st;
    pre_n = pre;
    en_n  = 1'b0;
    clr_n = 1'b0;
    case (st)
      ST_IDLE: begin
        pre_n = '0;
        if (ev_clr) begin
          clr_n = 1'b1;
        end else if (ev_start) begin
          st_n = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (ev_clr) begin
          st_n  = ST_IDLE;
          clr_n = 1'b1;
          pre_n = '0;
        end else if (ev_start && !at_max) begin
          // Prescaler kept: the fractional second survives the pause.
          st_n = ST_RUN;
        end
      end
      ST_RUN, ST_LAP: begin
        if (ev_start) begin
          // Pausing wins over a pending wrap; the tick is issued on resume.
          st_n = ST_PAUSE;
        end else begin
          if (ev_lap) st_n = (st == ST_RUN) ? ST_LAP : ST_RUN;
          if (!wrap) begin
            pre_n = pre + PW'(1);
          end else if (at_max) begin
            // Display frozen at 59:59; prescaler parked at its last value.
            st_n = ST_PAUSE;
          end else begin
            pre_n = '0;
            en_n  = 1'b1;
          end
        end
      end
      default: st_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st        <= ST_IDLE;
      pre       <= '0;
      CNT_EN    <= 1'b0;
      CNT_CLR   <= 1'b0;
      DISP_HOLD <= 1'b0;
      RUNNING   <= 1'b0;
    end else begin
      st        <= st_n;
      pre       <= pre_n;
      CNT_EN    <= en_n;
      CNT_CLR   <= clr_n;
      DISP_HOLD <= (st_n == ST_LAP);
      RUNNING   <= (st_n == ST_RUN) || (st_n == ST_LAP);
    end
  end

  assign STATE = st;

endmodule

// File: tb/tb_cronometro_ctrl.sv
// Bench for cronometro_ctrl with TICK_DIV=4, DEB_CYCLES=3.
// A behavioural model (sliding-window debounce, tick countdown, state table)
// predicts every output on every cycle; directed scenarios add absolute
// latency and count checks.
module tb_cronometro_ctrl;

  localparam int TD = 4;
  localparam int DB = 3;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_LAP   = 2'b11;

  // ---------------- clock / reset ----------------
  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       BTN_START = 1'b0;
  logic       BTN_CLR = 1'b0;
  logic       BTN_LAP = 1'b0;
`ifdef CRONO_AUTOSTOP_EN
  logic       MAX_REACHED = 1'b0;
`endif
  logic       CNT_EN;
  logic       CNT_CLR;
  logic       DISP_HOLD;
  logic       RUNNING;
  logic [1:0] STATE;

  always #5 CLK = ~CLK;

  cronometro_ctrl #(.TICK_DIV(TD), .DEB_CYCLES(DB)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .BTN_START(BTN_START),
    .BTN_CLR(BTN_CLR),
    .BTN_LAP(BTN_LAP),
`ifdef CRONO_AUTOSTOP_EN
    .MAX_REACHED(MAX_REACHED),
`endif
    .CNT_EN(CNT_EN),
    .CNT_CLR(CNT_CLR),
    .DISP_HOLD(DISP_HOLD),
    .RUNNING(RUNNING),
    .STATE(STATE)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [1:0]  m_st;
  int          m_left;          // running cycles until the next tick
  logic        m_en;
  logic        m_clr;
  logic [15:0] m_hist [3];      // raw samples, [0] = newest (0 start,1 clr,2 lap)
  logic        m_lvl  [3];
  logic        m_rise1[3];
  logic        m_rise2[3];

  task automatic model_reset();
    m_st   = S_IDLE;
    m_left = TD;
    m_en   = 1'b0;
    m_clr  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_hist[i]  = '0;
      m_lvl[i]   = 1'b0;
      m_rise1[i] = 1'b0;
      m_rise2[i] = 1'b0;
    end
  endtask

  task automatic model_step(input logic [2:0] b);
    logic ev_s, ev_c, ev_l, mx, all_diff, old;
    ev_s = m_rise2[0];
    ev_c = m_rise2[1];
    ev_l = m_rise2[2];
    mx = 1'b0;
`ifdef CRONO_AUTOSTOP_EN
    mx = MAX_REACHED;
`endif
    m_en  = 1'b0;
    m_clr = 1'b0;
    case (m_st)
      S_IDLE: begin
        if (ev_c) m_clr = 1'b1;
        else if (ev_s) begin m_st = S_RUN; m_left = TD; end
      end
      S_PAUSE: begin
        if (ev_c) begin m_st = S_IDLE; m_clr = 1'b1; m_left = TD; end
        else if (ev_s && !mx) m_st = S_RUN;
      end
      default: begin
        if (ev_s) m_st = S_PAUSE;
        else begin
          if (ev_l) m_st = (m_st == S_RUN) ? S_LAP : S_RUN;
          m_left--;
          if (m_left == 0) begin
            if (mx) begin m_st = S_PAUSE; m_left = 1; end
            else begin m_en = 1'b1; m_left = TD; end
          end
        end
      end
    endcase
    // Debounced level flips once the last DB synchronized samples (two
    // cycles old) all disagree with it.
    for (int i = 0; i < 3; i++) begin
      m_hist[i] = {m_hist[i][14:0], b[i]};
      all_diff = 1'b1;
      for (int j = 0; j < DB; j++)
        if (m_hist[i][2+j] == m_lvl[i]) all_diff = 1'b0;
      old = m_lvl[i];
      if (all_diff) m_lvl[i] = ~m_lvl[i];
      m_rise2[i] = m_rise1[i];
      m_rise1[i] = m_lvl[i] & ~old;
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drive, let the rising edge sample, compare at
  // the next falling edge.
  task automatic step(input logic s, input logic c, input logic l);
    BTN_START = s;
    BTN_CLR   = c;
    BTN_LAP   = l;
    @(posedge CLK);
    model_step({l, c, s});
    cyc++;
    @(negedge CLK);
    check_eq("state",     8'(STATE),     8'(m_st));
    check_eq("cnt_en",    8'(CNT_EN),    8'(m_en));
    check_eq("cnt_clr",   8'(CNT_CLR),   8'(m_clr));
    check_eq("disp_hold", 8'(DISP_HOLD), 8'(m_st == S_LAP));
    check_eq("running",   8'(RUNNING),   8'(m_st == S_RUN || m_st == S_LAP));
    check_eq("en_clr_excl", 8'(CNT_EN & CNT_CLR), 8'd0);
  endtask

  task automatic wait_en(output int at);
    at = -1;
    for (int i = 0; i < 2 * TD + 2 && at < 0; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (CNT_EN) at = cyc;
    end
    check_eq("wait_en_timeout", 8'(at >= 0), 8'd1);
  endtask

  task automatic press(input logic s, input logic c, input logic l, input int hold, input int gap);
    repeat (hold) step(s, c, l);
    repeat (gap) step(1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int run_at, en1, en2, t0, e_at, clr_cnt;
    logic [2:0] pat;
    int hold, gap;

    model_reset();
    repeat (2) @(negedge CLK);
    check_eq("rst_state",     8'(STATE),     8'd0);
    check_eq("rst_cnt_en",    8'(CNT_EN),    8'd0);
    check_eq("rst_cnt_clr",   8'(CNT_CLR),   8'd0);
    check_eq("rst_disp_hold", 8'(DISP_HOLD), 8'd0);
    check_eq("rst_running",   8'(RUNNING),   8'd0);
    RST_N = 1'b1;

    // Idle 20 cycles.
    repeat (20) step(1'b0, 1'b0, 1'b0);
    check_eq("idle_state", 8'(STATE), 8'(S_IDLE));

    // Start held 10 cycles: RUN 6 cycles after the press edge, ticks every 4.
    run_at = -1; en1 = -1; en2 = -1; t0 = cyc;
    for (int i = 1; i <= 20; i++) begin
      step(i <= 10, 1'b0, 1'b0);
      if (run_at < 0 && STATE == S_RUN) run_at = cyc - t0;
      if (CNT_EN && en1 < 0) en1 = cyc - t0;
      else if (CNT_EN && en2 < 0) en2 = cyc - t0;
    end
    check_eq("start_latency", 8'(run_at), 8'd7);
    check_eq("first_tick",    8'(en1),    8'd11);
    check_eq("tick_period",   8'(en2 - en1), 8'(TD));

    // Two-cycle glitch must not pause.
    press(1'b1, 1'b0, 1'b0, 2, 12);
    check_eq("glitch_state", 8'(STATE), 8'(S_RUN));

    // Lap in and out.
    press(1'b0, 1'b0, 1'b1, 5, 10);
    check_eq("lap_hold", 8'(DISP_HOLD), 8'd1);
    press(1'b0, 1'b0, 1'b1, 5, 10);
    check_eq("lap_release", 8'(DISP_HOLD), 8'd0);

    // Pause with prescaler at 2, then resume: tick 2 cycles after RUN.
    wait_en(e_at);
    press(1'b1, 1'b0, 1'b0, 5, 8);
    check_eq("pause_state", 8'(STATE), 8'(S_PAUSE));
    run_at = -1; en1 = -1;
    for (int i = 1; i <= 14; i++) begin
      step(i <= 5, 1'b0, 1'b0);
      if (run_at < 0 && STATE == S_RUN) run_at = cyc;
      if (en1 < 0 && CNT_EN) en1 = cyc;
    end
    check_eq("resume_tick_gap", 8'(en1 - run_at), 8'd2);

    // Pause, then clr+start together: IDLE with one CNT_CLR.
    press(1'b1, 1'b0, 1'b0, 5, 8);
    check_eq("pause2_state", 8'(STATE), 8'(S_PAUSE));
    clr_cnt = 0;
    for (int i = 1; i <= 15; i++) begin
      step(i <= 5, i <= 5, 1'b0);
      if (CNT_CLR) clr_cnt++;
    end
    check_eq("clr_pulses", 8'(clr_cnt), 8'd1);
    check_eq("clr_state",  8'(STATE),   8'(S_IDLE));

`ifdef CRONO_AUTOSTOP_EN
    // At max: next would-be tick pauses with no CNT_EN; start then ignored.
    press(1'b1, 1'b0, 1'b0, 5, 4);
    MAX_REACHED = 1'b1;
    en1 = 0;
    for (int i = 0; i < 2 * TD; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (CNT_EN) en1++;
    end
    check_eq("autostop_state", 8'(STATE), 8'(S_PAUSE));
    check_eq("autostop_no_en", 8'(en1),   8'd0);
    press(1'b1, 1'b0, 1'b0, 5, 8);
    check_eq("autostop_start_ignored", 8'(STATE), 8'(S_PAUSE));
    press(1'b0, 1'b1, 1'b0, 5, 8);
    MAX_REACHED = 1'b0;
`endif

    // Asynchronous reset mid-run.
    press(1'b1, 1'b0, 1'b0, 5, 4);
    check_eq("pre_reset_running", 8'(RUNNING), 8'd1);
    #2 RST_N = 1'b0;
    #1;
    check_eq("async_rst_state",   8'(STATE),   8'd0);
    check_eq("async_rst_running", 8'(RUNNING), 8'd0);
    check_eq("async_rst_en",      8'(CNT_EN),  8'd0);
    #1 RST_N = 1'b1;
    model_reset();

    // Randomized button activity.
    for (int s = 0; s < 150; s++) begin
      pat  = 3'($urandom_range(1, 7));
      hold = $urandom_range(1, 8);
      gap  = $urandom_range(1, 14);
`ifdef CRONO_AUTOSTOP_EN
      MAX_REACHED = ($urandom_range(0, 5) == 0);
`endif
      press(pat[0], pat[1], pat[2], hold, gap);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
